// File: rtl/pipe_stage_latch_if.sv
// ----------------------------------------------------------------------------
// pipe_stage_latch_if : valid/ready bus between two pipeline stages
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface pipe_stage_latch_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned FIELDS = 4,
  parameter int unsigned CNT_W  = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic [FIELDS*WIDTH-1:0]   in_data;
  logic                      exc_valid;
  logic [WIDTH-1:0]          exc_value;
  logic                      flush;
  logic                      inject_nop;
  logic                      out_valid;
  logic                      out_ready;
  logic [FIELDS*WIDTH-1:0]   out_data;
  logic [1:0]                occupancy;
  logic [CNT_W-1:0]          stall_cycles;

  modport master (
    output in_valid, in_data, exc_valid, exc_value, flush, inject_nop, out_ready,
    input  in_ready, out_valid, out_data, occupancy, stall_cycles
  );

  modport slave (
    input  in_valid, in_data, exc_valid, exc_value, flush, inject_nop, out_ready,
    output in_ready, out_valid, out_data, occupancy, stall_cycles
  );
endinterface

`default_nettype wire

// File: rtl/pipe_stage_latch.sv
// ----------------------------------------------------------------------------
// pipe_stage_latch : 2-entry skid-buffered inter-stage latch with flush,
//                    bubble injection, exception override and stall counter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pipe_stage_latch #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned FIELDS = 4,
  parameter logic [31:0] NOP_IR = 32'h0000_0000,
  parameter logic [31:0] EXC_IR = 32'h0780_0000,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  pipe_stage_latch_if.slave bus
);
  localparam int unsigned        c_dw       = FIELDS * WIDTH;
  localparam logic [WIDTH-1:0]   c_nop_ir   = WIDTH'(NOP_IR);
  localparam logic [WIDTH-1:0]   c_exc_ir   = WIDTH'(EXC_IR);
  localparam logic [c_dw-1:0]    c_nop_word = {{(c_dw-WIDTH){1'b0}}, c_nop_ir};
  localparam logic [CNT_W-1:0]   c_cnt_max  = '1;

  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [c_dw-1:0]   main_data_q,  main_data_d;
  logic [c_dw-1:0]   skid_data_q,  skid_data_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_emit;
  logic              w_bubble;
  logic              w_enq_valid;
  logic [c_dw-1:0]   w_enq_word;

  // Ready depends only on registered skid state and control inputs, never on out_ready.
  assign w_in_ready  = ~reset & ~skid_valid_q & ~bus.inject_nop & ~bus.flush;
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_emit      = main_valid_q & bus.out_ready;
  assign w_bubble    = bus.inject_nop & ~skid_valid_q & ~bus.flush;
  assign w_enq_valid = w_bubble | w_accept;

  always_comb begin
    w_enq_word = bus.in_data;
    if (w_bubble) begin
      w_enq_word = c_nop_word;
    end else if (bus.exc_valid) begin
      w_enq_word[0 +: WIDTH]     = c_exc_ir;
      w_enq_word[WIDTH +: WIDTH] = bus.exc_value;
    end
  end

  always_comb begin
    main_valid_d   = main_valid_q;
    skid_valid_d   = skid_valid_q;
    main_data_d    = main_data_q;
    skid_data_d    = skid_data_q;
    stall_cycles_d = stall_cycles_q;

    if (bus.flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_data_d  = c_nop_word;
    end else if (!main_valid_q || w_emit) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = w_enq_valid;
        if (w_enq_valid) begin
          skid_data_d = w_enq_word;
        end
      end else begin
        main_valid_d = w_enq_valid;
        if (w_enq_valid) begin
          main_data_d = w_enq_word;
        end
      end
    end else if (w_enq_valid) begin
      skid_valid_d = 1'b1;
      skid_data_d  = w_enq_word;
    end

    if (main_valid_q && !bus.out_ready && !bus.flush && (stall_cycles_q != c_cnt_max)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      main_valid_q   <= 1'b0;
      skid_valid_q   <= 1'b0;
      main_data_q    <= c_nop_word;
      skid_data_q    <= c_nop_word;
      stall_cycles_q <= '0;
    end else begin
      main_valid_q   <= main_valid_d;
      skid_valid_q   <= skid_valid_d;
      main_data_q    <= main_data_d;
      skid_data_q    <= skid_data_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = main_valid_q;
  assign bus.out_data     = main_data_q;
  assign bus.occupancy    = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
  assign bus.stall_cycles = stall_cycles_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_latch.sv
// ----------------------------------------------------------------------------
// tb_pipe_stage_latch : directed self-checking bench for pipe_stage_latch
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pipe_stage_latch;
  localparam int unsigned W  = 32;
  localparam int unsigned F  = 4;
  localparam int unsigned CW = 16;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] EXC = 32'h0780_0000;

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;

  pipe_stage_latch_if #(.WIDTH(W), .FIELDS(F), .CNT_W(CW)) bus ();

  pipe_stage_latch #(
    .WIDTH(W), .FIELDS(F), .NOP_IR(NOP), .EXC_IR(EXC), .CNT_W(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [F*W-1:0] mk(input logic [31:0] f0, f1, f2, f3);
    return {f3, f2, f1, f0};
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.exc_valid  = 1'b0;
    bus.exc_value  = '0;
    bus.flush      = 1'b0;
    bus.inject_nop = 1'b0;
    bus.out_ready  = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    cyc();
    cyc();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
    n_tests++; if (bus.occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d want 0", bus.occupancy); end
    n_tests++; if (bus.stall_cycles !== 16'd0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", bus.stall_cycles); end
    n_tests++; if (bus.out_data !== mk(NOP, 0, 0, 0)) begin n_fail++; $display("FAIL reset_out_data: got %h want %h", bus.out_data, mk(NOP, 0, 0, 0)); end
    bus.in_valid = 1'b1;
    #1;
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 0", bus.in_ready); end
    bus.in_valid = 1'b0;
    reset = 1'b0;
    #1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %0b want 1", bus.in_ready); end
  endtask

  task automatic test_streaming();
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = mk(i, 32'h100 + i, 32'h200 + i, 32'h300 + i);
      #1;
      n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d]: got %0b want 1", i, bus.in_ready); end
      cyc();
      n_tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== mk(i, 32'h100 + i, 32'h200 + i, 32'h300 + i)) begin
        n_fail++; $display("FAIL stream_out[%0d]: got v=%0b d=%h want v=1 d=%h", i, bus.out_valid, bus.out_data, mk(i, 32'h100 + i, 32'h200 + i, 32'h300 + i));
      end
      n_tests++; if (bus.occupancy !== 2'd1) begin n_fail++; $display("FAIL stream_occ[%0d]: got %0d want 1", i, bus.occupancy); end
    end
    bus.in_valid = 1'b0;
    cyc();
    n_tests++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0) begin n_fail++; $display("FAIL stream_drain: got v=%0b occ=%0d want v=0 occ=0", bus.out_valid, bus.occupancy); end
    n_tests++; if (bus.stall_cycles !== 16'd0) begin n_fail++; $display("FAIL stream_stall: got %0d want 0", bus.stall_cycles); end
  endtask

  task automatic test_back_pressure();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = mk(32'hA, 1, 2, 3);
    cyc();
    bus.in_data   = mk(32'hB, 4, 5, 6);
    cyc();
    n_tests++; if (bus.occupancy !== 2'd2) begin n_fail++; $display("FAIL bp_occ_full: got %0d want 2", bus.occupancy); end
    bus.in_data   = mk(32'hC, 7, 8, 9);
    #1;
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %0b want 0", bus.in_ready); end
    cyc();
    n_tests++; if (bus.out_data !== mk(32'hA, 1, 2, 3) || bus.occupancy !== 2'd2) begin n_fail++; $display("FAIL bp_hold: got d=%h occ=%0d want d=%h occ=2", bus.out_data, bus.occupancy, mk(32'hA, 1, 2, 3)); end
    n_tests++; if (bus.stall_cycles !== 16'd2) begin n_fail++; $display("FAIL bp_stall: got %0d want 2", bus.stall_cycles); end
    bus.out_ready = 1'b1;
    cyc();
    n_tests++; if (bus.out_data !== mk(32'hB, 4, 5, 6) || bus.occupancy !== 2'd1) begin n_fail++; $display("FAIL bp_second: got d=%h occ=%0d want d=%h occ=1", bus.out_data, bus.occupancy, mk(32'hB, 4, 5, 6)); end
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back: got %0b want 1", bus.in_ready); end
    cyc();
    n_tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== mk(32'hC, 7, 8, 9)) begin n_fail++; $display("FAIL bp_third: got v=%0b d=%h want v=1 d=%h", bus.out_valid, bus.out_data, mk(32'hC, 7, 8, 9)); end
    bus.in_valid = 1'b0;
    cyc();
    n_tests++; if (bus.occupancy !== 2'd0 || bus.stall_cycles !== 16'd2) begin n_fail++; $display("FAIL bp_done: got occ=%0d stall=%0d want occ=0 stall=2", bus.occupancy, bus.stall_cycles); end
  endtask

  task automatic test_exception();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = mk(32'h0000_1234, 32'h55, 32'hAA, 32'hBB);
    bus.exc_valid = 1'b1;
    bus.exc_value = 32'd3;
    cyc();
    n_tests++; if (bus.out_data !== mk(32'h0780_0000, 32'd3, 32'hAA, 32'hBB)) begin n_fail++; $display("FAIL exc_word: got %h want %h", bus.out_data, mk(32'h0780_0000, 32'd3, 32'hAA, 32'hBB)); end
    bus.exc_valid = 1'b0;
    bus.in_data   = mk(32'h0000_1234, 32'h55, 32'hAA, 32'hBB);
    cyc();
    n_tests++; if (bus.out_data !== mk(32'h0000_1234, 32'h55, 32'hAA, 32'hBB)) begin n_fail++; $display("FAIL exc_clear: got %h want %h", bus.out_data, mk(32'h0000_1234, 32'h55, 32'hAA, 32'hBB)); end
    bus.in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_bubble();
    bus.out_ready  = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_data    = mk(32'h77, 1, 2, 3);
    bus.exc_valid  = 1'b1;
    bus.exc_value  = 32'h99;
    bus.inject_nop = 1'b1;
    #1;
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bubble_in_ready: got %0b want 0", bus.in_ready); end
    cyc();
    n_tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== mk(NOP, 0, 0, 0)) begin n_fail++; $display("FAIL bubble_word: got v=%0b d=%h want v=1 d=%h", bus.out_valid, bus.out_data, mk(NOP, 0, 0, 0)); end
    bus.inject_nop = 1'b0;
    bus.exc_valid  = 1'b0;
    cyc();
    n_tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== mk(32'h77, 1, 2, 3)) begin n_fail++; $display("FAIL bubble_follow: got v=%0b d=%h want v=1 d=%h", bus.out_valid, bus.out_data, mk(32'h77, 1, 2, 3)); end
    bus.in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = mk(32'h11, 1, 1, 1);
    cyc();
    bus.in_data   = mk(32'h22, 2, 2, 2);
    cyc();
    n_tests++; if (bus.occupancy !== 2'd2) begin n_fail++; $display("FAIL flush_pre_occ: got %0d want 2", bus.occupancy); end
    bus.flush   = 1'b1;
    bus.in_data = mk(32'h33, 3, 3, 3);
    cyc();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    n_tests++; if (bus.occupancy !== 2'd0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got occ=%0d v=%0b want occ=0 v=0", bus.occupancy, bus.out_valid); end
    n_tests++; if (bus.out_data[W-1:0] !== NOP) begin n_fail++; $display("FAIL flush_ir: got %h want %h", bus.out_data[W-1:0], NOP); end
    cyc();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_accept: got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid_stall();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = mk(32'h44, 4, 4, 4);
    cyc();
    bus.in_data   = mk(32'h55, 5, 5, 5);
    cyc();
    bus.in_valid  = 1'b0;
    repeat (6) cyc();
    n_tests++; if (bus.occupancy !== 2'd2 || bus.stall_cycles !== 16'd7) begin n_fail++; $display("FAIL midstall_pre: got occ=%0d stall=%0d want occ=2 stall=7", bus.occupancy, bus.stall_cycles); end
    reset = 1'b1;
    cyc();
    n_tests++; if (bus.occupancy !== 2'd0 || bus.out_valid !== 1'b0 || bus.stall_cycles !== 16'd0) begin
      n_fail++; $display("FAIL midstall_reset: got occ=%0d v=%0b stall=%0d want 0 0 0", bus.occupancy, bus.out_valid, bus.stall_cycles);
    end
    n_tests++; if (bus.out_data !== mk(NOP, 0, 0, 0)) begin n_fail++; $display("FAIL midstall_data: got %h want %h", bus.out_data, mk(NOP, 0, 0, 0)); end
    reset = 1'b0;
    cyc();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midstall_residual: got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_saturate();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = mk(32'h66, 6, 6, 6);
    cyc();
    bus.in_valid  = 1'b0;
    repeat (10) cyc();
    n_tests++; if (bus.stall_cycles !== 16'd10) begin n_fail++; $display("FAIL sat_count: got %0d want 10", bus.stall_cycles); end
    repeat (65524) cyc();
    n_tests++; if (bus.stall_cycles !== 16'hFFFE) begin n_fail++; $display("FAIL sat_near: got %h want fffe", bus.stall_cycles); end
    repeat (6) cyc();
    n_tests++; if (bus.stall_cycles !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h want ffff", bus.stall_cycles); end
    bus.out_ready = 1'b1;
    cyc();
    n_tests++; if (bus.out_valid !== 1'b0 || bus.stall_cycles !== 16'hFFFF) begin n_fail++; $display("FAIL sat_drain: got v=%0b stall=%h want v=0 stall=ffff", bus.out_valid, bus.stall_cycles); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    idle_inputs();
    test_reset();
    test_streaming();
    test_back_pressure();
    test_exception();
    test_bubble();
    test_flush();
    test_reset_mid_stall();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
